// File: rtl/grain_stream_decryptor_if.sv
// Link-side bundle for the Grain-style stream decryptor: control, seed,
// ciphertext input handshake and plaintext output handshake.
interface grain_stream_decryptor_if #(
  parameter int W = 8
) ();
  logic           start;
  logic [103:0]   seed_in;
  logic           busy;
  logic           init_done;
  logic           ct_valid;
  logic           ct_ready;
  logic [W-1:0]   ct_data;
  logic           pt_valid;
  logic           pt_ready;
  logic [W-1:0]   pt_data;

  modport master (
    output start, seed_in, ct_valid, ct_data, pt_ready,
    input  busy, init_done, ct_ready, pt_valid, pt_data
  );

  modport slave (
    input  start, seed_in, ct_valid, ct_data, pt_ready,
    output busy, init_done, ct_ready, pt_valid, pt_data
  );
endinterface

// File: rtl/grain_stream_decryptor.sv
// Receive-side stream cipher: 80-bit linear + 24-bit nonlinear shift registers,
// warm-up after seed load, then one keystream bit per clock XORed into W-bit words.
module grain_stream_decryptor #(
  parameter int W           = 8,
  parameter int INIT_CYCLES = 160
) (
  input logic                  clk,
  input logic                  rst_n,
  grain_stream_decryptor_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, READY, GEN, OUT} state_t;

  state_t          state, state_nxt;
  logic [79:0]     l;
  logic [23:0]     n;
  logic [CW-1:0]   bit_cnt;
  logic [IW-1:0]   init_cnt;
  logic [W-1:0]    ct_buf;
  logic [W-1:0]    pt_buf;
  logic            fl_bit, g_bit, z_bit;

  always_comb begin
    fl_bit = l[62] ^ l[51] ^ l[38] ^ l[23] ^ l[13] ^ l[0];
    g_bit  = n[0] ^ n[5] ^ n[6] ^ n[9] ^ n[17] ^ n[22]
           ^ (n[4] & n[13]) ^ (n[8] & n[16])
           ^ (n[5] ^ n[11] ^ n[14]) ^ (n[2] ^ n[5] ^ n[8] ^ n[10]);
    z_bit  = l[0] ^ l[3] ^ (l[1] & l[2]) ^ (n[1] & l[5]) ^ (n[3] & l[7])
           ^ (l[8] & l[13] & n[5]) ^ n[2];
  end

  // start overrides every state, so a coincident handshake is simply lost
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      LOAD:    state_nxt = (INIT_CYCLES == 0) ? READY : INIT;
      INIT:    if (init_cnt == IW'(INIT_CYCLES - 1)) state_nxt = READY;
      READY:   if (bus.ct_valid) state_nxt = GEN;
      GEN:     if (bit_cnt == CW'(W - 1)) state_nxt = OUT;
      OUT:     if (bus.pt_ready) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
    if (bus.start) state_nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      l        <= '0;
      n        <= '0;
      bit_cnt  <= '0;
      init_cnt <= '0;
      ct_buf   <= '0;
      pt_buf   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          l        <= bus.seed_in[79:0];
          n        <= bus.seed_in[103:80];
          init_cnt <= '0;
        end
        INIT: begin
          l        <= {fl_bit ^ z_bit, l[79:1]};
          n        <= {g_bit ^ l[0] ^ z_bit, n[23:1]};
          init_cnt <= init_cnt + 1'b1;
        end
        READY: begin
          bit_cnt <= '0;
          if (bus.ct_valid) ct_buf <= bus.ct_data;
        end
        GEN: begin
          l               <= {fl_bit, l[79:1]};
          n               <= {g_bit ^ l[0], n[23:1]};
          pt_buf[bit_cnt] <= ct_buf[bit_cnt] ^ z_bit;
          bit_cnt         <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == LOAD) || (state == INIT);
  assign bus.init_done = (state == READY) || (state == GEN) || (state == OUT);
  assign bus.ct_ready  = (state == READY);
  assign bus.pt_valid  = (state == OUT);
  assign bus.pt_data   = pt_buf;

endmodule
